serial_rx4: RTL and testbench

SERIAL_RX4 -- requirements
Module: serial_rx4

---
 rtl/serial_rx4.sv | 159 +++++++++++++++
 tb/tb_serial_rx4.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx4.sv
// Four-byte 8N1 serial receiver: assembles four consecutive bytes (LSB first,
// byte 0 lowest) into a 32-bit word, with frame-error and inter-byte timeout handling.
module serial_rx4 #(
   parameter int CLK_PER_BIT  = 50,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [31:0] data,
   output logic        new_data,
   output logic        frame_err,
   output logic        timeout,
   output logic        busy,
   output logic [2:0]  state_dbg
);

   localparam int CTR_W   = $clog2(CLK_PER_BIT);
   localparam int TMR_MAX = TIMEOUT_BITS * CLK_PER_BIT;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLK_PER_BIT - 1);
   localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(CLK_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START_BIT = 3'd1,
      S_DATA      = 3'd2,
      S_STOP_BIT  = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_s_q;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [31:0]      word_q, word_d;
   logic [31:0]      data_q, data_d;
   logic             new_data_q, new_data_d;
   logic             frame_err_q, frame_err_d;
   logic             timeout_q, timeout_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= S_IDLE;
         ctr_q       <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         timer_q     <= '0;
         word_q      <= '0;
         data_q      <= '0;
         new_data_q  <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         timer_q     <= timer_d;
         word_q      <= word_d;
         data_q      <= data_d;
         new_data_q  <= new_data_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      timer_d     = '0;
      word_d      = word_q;
      data_d      = data_q;
      new_data_d  = 1'b0;
      frame_err_d = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Timer only runs while a partial word is pending; any exit clears it.
            if (!rx_s_q) begin
               state_d = S_START_BIT;
               ctr_d   = '0;
            end else if (byte_cnt_q != 2'd0) begin
               if (timer_q == TMR_LAST) begin
                  timeout_d  = 1'b1;
                  byte_cnt_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end
         S_START_BIT: begin
            if (ctr_q == CTR_HALF) begin
               ctr_d = '0;
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               ctr_d = ctr_q + 1'b1;
            end
         end
         S_DATA: begin
            if (ctr_q == CTR_LAST) begin
               word_d[{byte_cnt_q, bit_cnt_q}] = rx_s_q;
               ctr_d     = '0;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = S_STOP_BIT;
            end else begin
               ctr_d = ctr_q + 1'b1;
            end
         end
         S_STOP_BIT: begin
            // Sampled mid-bit, so IDLE is re-entered half a bit early for zero-gap bytes.
            if (ctr_q == CTR_LAST) begin
               ctr_d = '0;
               if (rx_s_q) begin
                  state_d    = S_IDLE;
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  if (byte_cnt_q == 2'd3) begin
                     data_d     = word_q;
                     new_data_d = 1'b1;
                  end
               end else begin
                  state_d     = S_WAIT_HIGH;
                  frame_err_d = 1'b1;
                  byte_cnt_d  = '0;
                  word_d      = '0;
               end
            end else begin
               ctr_d = ctr_q + 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign data      = data_q;
   assign new_data  = new_data_q;
   assign frame_err = frame_err_q;
   assign timeout   = timeout_q;
   assign busy      = (state_q != S_IDLE) || (byte_cnt_q != 2'd0);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_rx4.sv
// Bench for serial_rx4: random and directed byte streams checked against a
// byte-level model that groups accepted bytes into words.
module tb_serial_rx4;

   localparam int CPB = 50;
   localparam int TOB = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx  = 1'b1;
   logic [31:0] data;
   logic        new_data, frame_err, timeout, busy;
   logic [2:0]  state_dbg;

   int tests_run = 0;
   int fails     = 0;

   // Monitor-owned observations
   logic [31:0] got_q[$];
   longint      nd_t_q[$];
   int          nd_cnt = 0, fe_cnt = 0, to_cnt = 0, viol_cnt = 0;
   longint      to_t = 0;
   logic        prev_pulse = 1'b0;
   logic [31:0] prev_data = '0;

   // Reference model: accepted bytes are buffered, four make a word
   logic [7:0]  buf_q[$];
   logic [31:0] exp_q[$];

   serial_rx4 #(.CLK_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data), .new_data(new_data),
      .frame_err(frame_err), .timeout(timeout), .busy(busy), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (new_data) begin
            got_q.push_back(data);
            nd_t_q.push_back($time);
            nd_cnt++;
         end
         if (frame_err) fe_cnt++;
         if (timeout) begin
            to_cnt++;
            to_t = $time;
         end
         if ((int'(new_data) + int'(frame_err) + int'(timeout)) > 1) viol_cnt++;
         if ((new_data | frame_err | timeout) && prev_pulse) viol_cnt++;
         if ((data !== prev_data) && !new_data) viol_cnt++;
      end
      prev_pulse = new_data | frame_err | timeout;
      prev_data  = data;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_clear();
      buf_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(CPB);
      end
      rx = stop_v;
      idle(CPB);
      if (stop_v) begin
         buf_q.push_back(b);
         if (buf_q.size() == 4) begin
            exp_q.push_back({buf_q[3], buf_q[2], buf_q[1], buf_q[0]});
            buf_q.delete();
         end
      end else begin
         buf_q.delete();
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int k = 0; k < 4; k++) begin
         send_byte(w[8*k +: 8], 1'b1);
         if (max_gap > 0 && k < 3) idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic test_reset();
      idle(3);
      tests_run++;
      if ({data, new_data, frame_err, timeout, busy} !== 36'h0) begin
         fails++;
         $display("FAIL reset_outputs: got data=%h nd=%b fe=%b to=%b busy=%b, expected all zero",
                  data, new_data, frame_err, timeout, busy);
      end
      rst = 1'b1;
      idle(30);
      tests_run++;
      if (busy !== 1'b0 || nd_cnt + fe_cnt + to_cnt !== 0) begin
         fails++;
         $display("FAIL reset_release: got busy=%b pulses=%0d, expected busy=0 pulses=0",
                  busy, nd_cnt + fe_cnt + to_cnt);
      end
   endtask

   task automatic test_basic_word();
      int base = got_q.size();
      int fe0 = fe_cnt, to0 = to_cnt;
      exp_q.delete();
      send_byte(8'h5A, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'hC3, 1'b1);
      send_byte(8'hA5, 1'b1);
      idle(20);
      tests_run++;
      if (got_q.size() - base !== 1) begin
         fails++;
         $display("FAIL basic_count: got %0d words, expected 1", got_q.size() - base);
      end else begin
         tests_run++;
         if (got_q[base] !== 32'hA5C33C5A) begin
            fails++;
            $display("FAIL basic_data: got %h expected %h", got_q[base], 32'hA5C33C5A);
         end
      end
      tests_run++;
      if (fe_cnt !== fe0 || to_cnt !== to0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_clean: got fe=%0d to=%0d busy=%b, expected 0 0 0",
                  fe_cnt - fe0, to_cnt - to0, busy);
      end
   endtask

   task automatic test_false_start();
      int n0 = nd_cnt + fe_cnt + to_cnt;
      int base = got_q.size();
      logic [31:0] w = $urandom;
      exp_q.delete();
      rx = 1'b0;
      idle(10);
      rx = 1'b1;
      idle(100);
      tests_run++;
      if (nd_cnt + fe_cnt + to_cnt !== n0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL false_start: got pulses=%0d busy=%b, expected 0 0",
                  nd_cnt + fe_cnt + to_cnt - n0, busy);
      end
      send_word(w, 0);
      idle(20);
      tests_run++;
      if (got_q.size() - base !== 1 || got_q[got_q.size()-1] !== exp_q[0]) begin
         fails++;
         $display("FAIL false_start_word: got %0d words last=%h, expected 1 word %h",
                  got_q.size() - base, got_q[got_q.size()-1], exp_q[0]);
      end
   endtask

   task automatic test_frame_err();
      int base = got_q.size();
      int fe0 = fe_cnt;
      exp_q.delete();
      send_byte(8'h77, 1'b1);
      send_byte(8'h99, 1'b0);
      idle(150);
      tests_run++;
      if (fe_cnt - fe0 !== 1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL frame_err_pulse: got fe=%0d busy=%b, expected 1 1", fe_cnt - fe0, busy);
      end
      rx = 1'b1;
      idle(20);
      tests_run++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL frame_err_recover: got busy=%b expected 0", busy);
      end
      send_word(32'h44332211, 0);
      idle(20);
      tests_run++;
      if (got_q.size() - base !== 1 || got_q[got_q.size()-1] !== 32'h44332211) begin
         fails++;
         $display("FAIL frame_err_word: got %0d words last=%h, expected 1 word 44332211",
                  got_q.size() - base, got_q[got_q.size()-1]);
      end
   endtask

   task automatic test_timeout();
      int base = got_q.size();
      int to0 = to_cnt;
      longint t_ret;
      logic [31:0] w = $urandom;
      exp_q.delete();
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      t_ret = $time;
      idle(1100);
      model_clear();
      tests_run++;
      if (to_cnt - to0 !== 1 || busy !== 1'b0 || got_q.size() !== base) begin
         fails++;
         $display("FAIL timeout_pulse: got to=%0d busy=%b words=%0d, expected 1 0 0",
                  to_cnt - to0, busy, got_q.size() - base);
      end
      // Stop sample lands 22 cycles before the stop bit ends; timeout follows 1000 cycles later.
      tests_run++;
      if ((to_t - t_ret) < 64'd9770 || (to_t - t_ret) > 64'd9790) begin
         fails++;
         $display("FAIL timeout_time: got %0d time units after stop bit, expected 9780", to_t - t_ret);
      end
      send_word(w, 0);
      idle(20);
      tests_run++;
      if (got_q.size() - base !== 1 || got_q[got_q.size()-1] !== w) begin
         fails++;
         $display("FAIL timeout_next_word: got %0d words last=%h, expected 1 word %h",
                  got_q.size() - base, got_q[got_q.size()-1], w);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      exp_q.delete();
      send_byte(8'h10, 1'b1);
      send_byte(8'h20, 1'b1);
      rx = 1'b0;
      idle(CPB);
      rx = 1'b1; idle(CPB);
      rx = 1'b0; idle(CPB);
      rx = 1'b1; idle(20);
      rst = 1'b0;
      model_clear();
      idle(5);
      tests_run++;
      if (data !== 32'h0 || busy !== 1'b0 || new_data !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: got data=%h busy=%b nd=%b, expected 0 0 0", data, busy, new_data);
      end
      rst = 1'b1;
      idle(20);
      base = got_q.size();
      send_word(32'hDDCCBBAA, 0);
      idle(20);
      tests_run++;
      if (got_q.size() - base !== 1 || got_q[got_q.size()-1] !== 32'hDDCCBBAA) begin
         fails++;
         $display("FAIL reset_mid_word: got %0d words last=%h, expected 1 word ddccbbaa",
                  got_q.size() - base, got_q[got_q.size()-1]);
      end
   endtask

   task automatic test_back_to_back();
      int base = got_q.size();
      exp_q.delete();
      send_word(32'h12345678, 0);
      send_word(32'hDEADBEEF, 0);
      idle(20);
      tests_run++;
      if (got_q.size() - base !== 2) begin
         fails++;
         $display("FAIL b2b_count: got %0d words, expected 2", got_q.size() - base);
      end else begin
         tests_run++;
         if (got_q[base] !== 32'h12345678 || got_q[base+1] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL b2b_data: got %h %h expected 12345678 deadbeef", got_q[base], got_q[base+1]);
         end
         tests_run++;
         if (nd_t_q[base+1] - nd_t_q[base] !== 64'd20000) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d time units, expected 20000",
                     nd_t_q[base+1] - nd_t_q[base]);
         end
      end
   endtask

   task automatic test_random();
      int base = got_q.size();
      exp_q.delete();
      for (int n = 0; n < 6; n++) begin
         send_word($urandom, 300);
         idle($urandom_range(0, 300));
      end
      idle(20);
      tests_run++;
      if (got_q.size() - base !== exp_q.size()) begin
         fails++;
         $display("FAIL random_count: got %0d words, expected %0d", got_q.size() - base, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (got_q[base+i] !== exp_q[i]) begin
               fails++;
               $display("FAIL random_word%0d: got %h expected %h", i, got_q[base+i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_protocol();
      tests_run++;
      if (viol_cnt !== 0) begin
         fails++;
         $display("FAIL pulse_protocol: got %0d violations, expected 0", viol_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic_word();
      test_false_start();
      test_frame_err();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
